// File: rtl/masked_share_compress_reg_pkg.sv
// Share geometry for the 3-share masked PRINCE S-box compression stage: 9 expanded shares
// per output bit fold into 3 shares as 3 groups of 3.
package masked_share_compress_reg_pkg;
    localparam int NSHARES_IN  = 9;
    localparam int NSHARES_OUT = 3;
    localparam int GROUP       = 3;
    localparam int NBITS_DEF   = 4;

    typedef logic [NSHARES_OUT*NBITS_DEF-1:0] ysh_word_t;

    function automatic int in_idx(input int bit_i, input int share_j, input int member_k);
        return NSHARES_IN*bit_i + GROUP*share_j + member_k;
    endfunction

    function automatic int out_idx(input int bit_i, input int share_j);
        return NSHARES_OUT*bit_i + share_j;
    endfunction
endpackage

// File: rtl/masked_share_compress_reg_share_compress3.sv
// Combinational 9->3 share compression for one output bit; ring refresh when SHARE_REFRESH_EN.
// Zero latency, no flow control; the XOR of the three outputs always equals the XOR of x_i.
module share_compress3
    import masked_share_compress_reg_pkg::*;
(
    input  logic [NSHARES_IN-1:0]  x_i,
    input  logic [NSHARES_OUT-1:0] r_i,
    output logic [NSHARES_OUT-1:0] y_o
);
    logic [NSHARES_OUT-1:0] grp;

    always_comb begin
        grp = '0;
        for (int j = 0; j < NSHARES_OUT; j++) begin
            grp[j] = ^x_i[GROUP*j +: GROUP];
        end
    end

`ifdef SHARE_REFRESH_EN
    // Each random bit lands in exactly two shares, so the unmasked value is preserved.
    assign y_o = grp ^ {r_i[2] ^ r_i[0], r_i[1] ^ r_i[2], r_i[0] ^ r_i[1]};
`else
    logic unused_r;
    assign unused_r = ^r_i;
    assign y_o      = grp;
`endif
endmodule

// File: rtl/masked_share_compress_reg.sv
// Two-entry elastic stage: register expanded shares (glitch barrier), then compress 9->3 per bit.
// Latency 2 cycles, 1 word/cycle; in_ready drops only when both stages are full and stalled. Macro SHARE_REFRESH_EN.
module masked_share_compress_reg
    import masked_share_compress_reg_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NSHARES_IN*NBITS-1:0] q_exp,
    input  logic [NSHARES_OUT*NBITS-1:0] r_ref,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NSHARES_OUT*NBITS-1:0] y_sh,
    output logic [CNT_W-1:0]            done_cnt
);
    logic [NSHARES_IN*NBITS-1:0]  capa_q;
    logic                         va_q, va_d;
    logic                         vb_q, vb_d;
    logic [NSHARES_OUT*NBITS-1:0] y_q, y_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         advance, accept, drain;

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_bit
            share_compress3 u_cmp (
                .x_i (capa_q[NSHARES_IN*gi +: NSHARES_IN]),
                .r_i (r_ref[NSHARES_OUT*gi +: NSHARES_OUT]),
                .y_o (y_d[NSHARES_OUT*gi +: NSHARES_OUT])
            );
        end
    endgenerate

    assign advance = va_q && (!vb_q || out_ready);
    assign in_ready = !va_q || advance;
    assign accept  = in_valid && in_ready;
    assign drain   = vb_q && out_ready;

    always_comb begin
        va_d  = va_q;
        vb_d  = vb_q;
        cnt_d = cnt_q;
        if (accept) begin
            va_d = 1'b1;
        end else if (advance) begin
            va_d = 1'b0;
        end
        if (advance) begin
            vb_d = 1'b1;
        end else if (drain) begin
            vb_d = 1'b0;
        end
        if (drain) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            capa_q <= '0;
            va_q   <= 1'b0;
            vb_q   <= 1'b0;
            y_q    <= '0;
            cnt_q  <= '0;
        end else begin
            // Stage A is pure flops: nothing combinational ahead of the glitch barrier.
            if (accept) begin
                capa_q <= q_exp;
            end
            if (advance) begin
                y_q <= y_d;
            end
            va_q  <= va_d;
            vb_q  <= vb_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = vb_q;
    assign y_sh      = y_q;
    assign done_cnt  = cnt_q;
endmodule

// File: tb/tb_masked_share_compress_reg.sv
// Scoreboard bench: the driver queues expected words on acceptance, a negedge monitor pops on transfer.
module tb_masked_share_compress_reg;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [35:0] q_exp;
    logic [11:0] r_ref;
    logic        in_ready, out_valid;
    logic [11:0] y_sh;
    logic [7:0]  done_cnt;

    masked_share_compress_reg #(.NBITS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .q_exp(q_exp),
        .r_ref(r_ref), .out_valid(out_valid), .out_ready(out_ready), .y_sh(y_sh), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_xfer = -1;
    bit chk_consec = 1'b0;
    logic [7:0]  exp_done = '0;
    logic [11:0] exp_y_q[$];
    logic [3:0]  exp_u_q[$];
    logic [11:0] mon_y;
    logic [3:0]  mon_u;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] model_y(input logic [35:0] q, input logic [11:0] r);
        logic [11:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                y[3*i+j] = q[9*i+3*j] ^ q[9*i+3*j+1] ^ q[9*i+3*j+2];
            end
`ifdef SHARE_REFRESH_EN
            y[3*i+0] = y[3*i+0] ^ r[3*i+0] ^ r[3*i+1];
            y[3*i+1] = y[3*i+1] ^ r[3*i+1] ^ r[3*i+2];
            y[3*i+2] = y[3*i+2] ^ r[3*i+2] ^ r[3*i+0];
`endif
        end
        return y;
    endfunction

    function automatic logic [3:0] unm_in(input logic [35:0] q);
        logic [3:0] u;
        for (int i = 0; i < 4; i++) u[i] = ^q[9*i +: 9];
        return u;
    endfunction

    function automatic logic [3:0] unm_out(input logic [11:0] y);
        logic [3:0] u;
        for (int i = 0; i < 4; i++) u[i] = ^y[3*i +: 3];
        return u;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("done_cnt_before_xfer", done_cnt, exp_done);
            if (exp_y_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y_sh=%0h expected no output (cycle %0d)", y_sh, cyc);
            end else begin
                mon_y = exp_y_q.pop_front();
                mon_u = exp_u_q.pop_front();
                check("y_sh", y_sh, mon_y);
                check("unmasked", unm_out(y_sh), mon_u);
            end
            if (chk_consec && last_xfer >= 0) check("consecutive_out", cyc, last_xfer + 1);
            last_xfer = cyc;
            exp_done  = exp_done + 8'd1;
        end
    end

    task automatic step(input logic [35:0] q, input logic [11:0] r, output bit acc);
        in_valid = 1'b1;
        q_exp    = q;
        r_ref    = r;
        @(negedge clk);
        acc = in_ready;
        if (acc) begin
            exp_y_q.push_back(model_y(q, r));
            exp_u_q.push_back(unm_in(q));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [35:0] q, input logic [11:0] r);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) step(q, r, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_y_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", exp_y_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [35:0] words [8] = '{36'h123456789, 36'hFFFFFFFFF, 36'h000000000, 36'hA5A5A5A5A,
                              36'h5A5A5A5A5, 36'h000000001, 36'h800000000, 36'hDEADBEEF0};
    logic [35:0] bp_w [3] = '{36'h0000001C0, 36'h0F0F0F0F0, 36'h7FFFFFFFF};

    initial begin
        bit acc;
        int idx, t0;
        logic [11:0] held;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        q_exp = 36'hABCDE1234; r_ref = 12'h5A5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; r_ref = '0;
        check("rst_out_valid", out_valid, 0);
        check("rst_y_sh", y_sh, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        send(36'h1FF, 12'h000);
        check("lat_out_valid_c1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_out_valid_c2", out_valid, 1);
        check("single_y_sh", y_sh, 12'h007);
        @(posedge clk);
        #1;
        check("single_done_cnt", done_cnt, 1);

        chk_consec = 1'b1;
        last_xfer  = -1;
        t0 = cyc;
        foreach (words[k]) send(words[k], 12'h000);
        check("stream_accept_cycles", cyc - t0, 8);
        drain();
        chk_consec = 1'b0;

        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(bp_w[idx], 12'h000, acc);
            if (acc) idx++;
            if (c == 2) held = y_sh;
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_y_stable", y_sh, held);
        check("bp_y_first", y_sh, 12'h004);
        out_ready = 1'b1;
        send(bp_w[2], 12'h000);
        drain();

        out_ready = 1'b0;
        send(36'h111111111, 12'h000);
        send(36'h222222222, 12'h000);
        rst = 1'b1;
        exp_y_q.delete();
        exp_u_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_done = '0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done_cnt", done_cnt, 0);
        check("midrst_y_sh", y_sh, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_output", done_cnt, 0);

        for (int k = 0; k < 260; k++) send(36'(k) * 36'h10001, 12'h000);
        drain();
        check("wrap_done_cnt", done_cnt, 8'd4);

`ifdef SHARE_REFRESH_EN
        send(36'h0, 12'hFFF);
        @(posedge clk);
        #1;
        check("refresh_fff", y_sh, 12'h000);
        drain();
        send(36'h0, 12'h001);
        @(posedge clk);
        #1;
        check("refresh_001", y_sh, 12'h005);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/masked_share_compress_reg.md
Name: masked_share_compress_reg

Overview:
- Downstream stage of the 3-share masked PRINCE S-box coordinate functions.
- Each S-box output bit is produced as 9 expanded share bits by 9 coordinate-function instances. This block first registers all 9 bits as a glitch barrier.
- It then compresses the 9 bits back to 3 shares per output bit, with optional fresh-mask refresh.
- It is an elastic valid/ready pipeline stage between S-box stages of the 4-stage S-box datapath.

Parameters:
- NBITS, 4, number of S-box output bits handled; each has 9 expanded shares in and 3 shares out.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  q_exp holds a valid expanded word
- in_ready  output  1  stage can accept q_exp this cycle
- q_exp  input  9*NBITS  expanded shares; bit 9*i+k is instance k of output bit i, k=0..8
- r_ref  input  3*NBITS  fresh randomness for refresh; ignored unless SHARE_REFRESH_EN is defined
- out_valid  output  1  y_sh holds a valid compressed word
- out_ready  input  1  consumer accepts y_sh
- y_sh  output  3*NBITS  compressed shares; bit 3*i+j is share j of output bit i
- done_cnt  output  CNT_W  number of completed output transfers, modulo 2^CNT_W

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On rst, every register clears at the next edge:
  - in_ready=1 from the first cycle after reset
  - out_valid=0, y_sh=0, done_cnt=0, internal stage-A data and valid=0
- Stage A (glitch barrier): pure flops with no logic before them.
  - On in_valid && in_ready: capA <= q_exp, vA <= 1.
- Stage B (compress): on the advance condition (vA && (!vB || out_ready)), load the compressed word and set vB <= 1:
  - y_sh[3i+j] <= capA[9i+3j] ^ capA[9i+3j+1] ^ capA[9i+3j+2]
- If vA is 0 while B drains (out_ready && vB), vB <= 0.
- vA clears when A advances into B and no new input is accepted in the same cycle.
- in_ready = !vA || advance. This is combinational from registered state and out_ready only; it never depends on in_valid.
- out_valid = vB. y_sh is held stable while out_valid && !out_ready.
- Latency: 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 word/cycle.
- Capacity is 2 words. When full (vA && vB && !out_ready), in_ready=0 and q_exp is not sampled.
- Simultaneous accept, advance and drain in one cycle are all legal. No word is lost or duplicated.
- done_cnt increments on out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- rst asserted mid-operation discards both stages; no partial output is produced.
- The compression XOR never combines shares across output bits.

Optional Feature:
- Macro SHARE_REFRESH_EN.
- Defined: stage B applies a ring refresh with r_ref sampled in the advance cycle:
  - y_sh[3i+0] ^= r[3i+0] ^ r[3i+1]
  - y_sh[3i+1] ^= r[3i+1] ^ r[3i+2]
  - y_sh[3i+2] ^= r[3i+2] ^ r[3i+0]
  - The unmasked value (XOR of the three shares) is unchanged.
  - Randomness must be held stable in the advance cycle; each advance consumes fresh bits.
- Undefined: r_ref is unused and the output is the plain 3-to-1 group XOR.

Decomposition:
- Shared package (e.g. prince_mask_pkg) holds:
  - NSHARES_IN=9, NSHARES_OUT=3, GROUP=3
  - share-index helper constants
  - the output-share word typedef sized by NBITS
- One natural sub-module: share_compress3, purely combinational, 9 bits plus optional 3 random bits in, 3 bits out. It is instantiated NBITS times inside stage B.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs -> out_valid=0, y_sh=0, done_cnt=0, in_ready=1 after release.
- Single word, NBITS=4, q_exp=36'h1FF, out_ready=1 -> exactly 2 cycles later out_valid=1 and y_sh=12'h007 (bit 0 shares = 1,1,1; others 0). done_cnt=1 after the transfer.
- Back-to-back stream of 8 random words, out_ready=1 -> 8 outputs on consecutive cycles. For every bit i, XOR of the 3 output shares equals XOR of its 9 input shares, in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts, y_sh stable. Release -> both words delivered in order with no loss.
- Mid-operation reset with 2 words buffered -> next cycle out_valid=0 and done_cnt=0. The buffered words never appear.
- With SHARE_REFRESH_EN and r_ref=12'hFFF, q_exp=0 -> y_sh=0, since each share gets 1^1. With r_ref=12'h001 -> bit 0 shares = 1,0,1 (XOR 0).
